// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counters paired with BTB slots.
// Predicts direction and target for if_pc, trains from execute, flags mispredicts.
//
// Ports:
//   clk, rst_n        core clock, synchronous active-low reset
//   if_pc             fetch PC to predict
//   pred_taken        predicted direction for if_pc
//   pred_target       predicted next PC for if_pc
//   ex_valid          execute instruction valid
//   ex_b_type         execute instruction is a conditional branch
//   ex_pc             PC of the execute instruction
//   ex_taken          resolved direction
//   ex_target         resolved branch target
//   ex_pred_taken     prediction carried down the pipe
//   ex_pred_target    predicted target carried down the pipe
//   mispredict        execute branch was mispredicted
//   redirect_pc       correct next PC for the execute branch
//   stat_branches     resolved branch count
//   stat_mispredicts  misprediction count
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_b_type,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q [N];
    logic [1:0]       ctr_q   [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [XLEN-1:0]  tgt_q   [N];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             upd;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = if_pc + XLEN'(4);
        if (if_hit && ctr_q[if_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = tgt_q[if_idx];
        end
    end

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // rst_n gates the update so a branch caught by reset is neither
    // trained nor counted, and cannot raise a flush.
    assign upd = ex_valid && ex_b_type && rst_n;

    assign mispredict = upd &&
        ((ex_taken != ex_pred_taken) ||
         (ex_taken && (ex_pred_target != ex_target)));

    assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    // Tag and target storage is deliberately left out of reset; valid
    // masks whatever they hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
            if (ex_hit) begin
                if (ex_taken) begin
                    tgt_q[ex_idx] <= ex_target;
                    if (ctr_q[ex_idx] != 2'b11)
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                end else begin
                    if (ctr_q[ex_idx] != 2'b00)
                        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= ex_target;
                ctr_q[ex_idx]   <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor.
// Table-driven vectors, expectations queued at drive time and checked pre-edge.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_b_type;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(4), .XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_b_type        (ex_b_type),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct packed {
        logic        rst_n;
        logic        exv;
        logic        exb;
        logic [31:0] ex_pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [31:0] if_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_redir;
        logic [31:0] e_sb;
        logic [31:0] e_sm;
    } vec_t;

    typedef struct packed {
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(
        input logic r, input logic v, input logic b,
        input logic [31:0] xpc, input logic t, input logic [31:0] tg,
        input logic pt, input logic [31:0] ptg, input logic [31:0] ipc,
        input logic ept, input logic [31:0] eptg, input logic emis,
        input logic [31:0] ered, input logic [31:0] esb,
        input logic [31:0] esm);
        vec_t x;
        x.rst_n = r;    x.exv = v;      x.exb = b;
        x.ex_pc = xpc;  x.tk = t;       x.tgt = tg;
        x.ptk = pt;     x.ptgt = ptg;   x.if_pc = ipc;
        x.e_pt = ept;   x.e_ptgt = eptg; x.e_mis = emis;
        x.e_redir = ered; x.e_sb = esb; x.e_sm = esm;
        return x;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h",
                     name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        rst_n          = v.rst_n;
        ex_valid       = v.exv;
        ex_b_type      = v.exb;
        ex_pc          = v.ex_pc;
        ex_taken       = v.tk;
        ex_target      = v.tgt;
        ex_pred_taken  = v.ptk;
        ex_pred_target = v.ptgt;
        if_pc          = v.if_pc;
        e.pt = v.e_pt;   e.ptgt = v.e_ptgt; e.mis = v.e_mis;
        e.redir = v.e_redir; e.sb = v.e_sb; e.sm = v.e_sm;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input int row);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard row %0d: got empty queue expected entry",
                     row);
            return;
        end
        e = sb_q.pop_front();
        chk("pred_taken",       row, {31'd0, pred_taken}, {31'd0, e.pt});
        chk("pred_target",      row, pred_target,         e.ptgt);
        chk("mispredict",       row, {31'd0, mispredict}, {31'd0, e.mis});
        chk("redirect_pc",      row, redirect_pc,         e.redir);
        chk("stat_branches",    row, stat_branches,       e.sb);
        chk("stat_mispredicts", row, stat_mispredicts,    e.sm);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_b_type = 1'b0;
        ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0; if_pc = 32'h100;

        //          r  v  b  ex_pc      tk tgt       ptk ptgt      if_pc      ept eptgt     mis redir      sb  sm
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h100,   0,32'h104, 0,32'h4,    0,0));
        vecs.push_back(mk(1,1,1,32'h100,  1,32'h80,  0,32'h104,  32'h100,   0,32'h104, 1,32'h80,   0,0));
        vecs.push_back(mk(1,0,0,32'h100,  0,32'h0,   0,32'h0,    32'h100,   1,32'h80,  0,32'h104,  1,1));
        vecs.push_back(mk(1,1,1,32'h100,  0,32'h80,  1,32'h80,   32'h100,   1,32'h80,  1,32'h104,  1,1));
        vecs.push_back(mk(1,1,1,32'h100,  0,32'h80,  0,32'h104,  32'h100,   0,32'h104, 0,32'h104,  2,2));
        vecs.push_back(mk(1,1,1,32'h100,  0,32'h80,  0,32'h104,  32'h100,   0,32'h104, 0,32'h104,  3,2));
        vecs.push_back(mk(1,1,1,32'h100,  1,32'h80,  0,32'h104,  32'h100,   0,32'h104, 1,32'h80,   4,2));
        vecs.push_back(mk(1,1,0,32'h100,  1,32'h44,  0,32'h104,  32'h100,   0,32'h104, 0,32'h44,   5,3));
        vecs.push_back(mk(1,1,1,32'h100,  1,32'h80,  0,32'h104,  32'h100,   0,32'h104, 1,32'h80,   5,3));
        vecs.push_back(mk(1,1,1,32'h500,  1,32'h300, 0,32'h504,  32'h100,   1,32'h80,  1,32'h300,  6,4));
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h100,   0,32'h104, 0,32'h4,    7,5));
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h500,   1,32'h300, 0,32'h4,    7,5));
        vecs.push_back(mk(1,1,1,32'h500,  1,32'h90,  1,32'h300,  32'h500,   1,32'h300, 1,32'h90,   7,5));
        vecs.push_back(mk(1,1,1,32'h500,  1,32'h90,  1,32'h90,   32'h500,   1,32'h90,  0,32'h90,   8,6));
        vecs.push_back(mk(1,1,1,32'h200,  1,32'h1000,0,32'h204,  32'h200,   0,32'h204, 1,32'h1000, 9,6));
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h200,   1,32'h1000,0,32'h4,    10,7));
        vecs.push_back(mk(1,0,0,32'hFFFFFFFC,0,32'h0,0,32'h0,    32'hFFFFFFFC,0,32'h0, 0,32'h0,    10,7));
        vecs.push_back(mk(0,1,1,32'h200,  0,32'h1000,1,32'h1000, 32'h200,   1,32'h1000,0,32'h204,  10,7));
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h200,   0,32'h204, 0,32'h4,    0,0));
        vecs.push_back(mk(1,1,1,32'h204,  0,32'h400, 0,32'h208,  32'h204,   0,32'h208, 0,32'h208,  0,0));
        vecs.push_back(mk(1,0,0,32'h0,    0,32'h0,   0,32'h0,    32'h204,   0,32'h208, 0,32'h4,    1,0));

        // Hold reset across two edges and confirm nothing escapes it.
        ex_valid = 1'b1; ex_b_type = 1'b1; ex_pc = 32'h100;
        ex_taken = 1'b1; ex_target = 32'h80;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_mispredict", -1, {31'd0, mispredict}, 32'd0);
        chk("reset_stat_br",    -1, stat_branches,       32'd0);
        chk("reset_pred_taken", -1, {31'd0, pred_taken}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check_out(i);
            @(negedge clk);
        end

        chk("scoreboard_drained", -2, sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
